// File: rtl/jtag_host_driver.sv
// jtag_host_driver
//   Command-driven JTAG host. One command at a time is accepted on a
//   valid/ready handshake. The driver then plays the matching TCK/TMS/TDI
//   sequence and returns the captured TDO bits on a valid/ready response.
//
//   TCK timing: every TCK period is TCK_DIV clk low, then TCK_DIV clk high.
//   TMS/TDI/TRST change at the clk edge that opens a low phase. TDO is sampled
//   at the clk edge that raises TCK.
//
// Ports
//   clk, reset             block clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_op                 00 RESET, 01 TRST, 10 SHIFT_IR, 11 SHIFT_DR
//   cmd_len_m1, cmd_data   shift length minus one, TDI bits (LSB first)
//   rsp_valid/rsp_ready    response handshake
//   rsp_data               captured TDO bits; bit i is the i-th shifted bit
//   tck, tms, tdi, trst    JTAG pins (trst active-low)
//   tdo                    JTAG TDO from the test logic
module jtag_host_driver #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len_m1,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  output logic        trst,
  input  logic        tdo
);

  typedef enum logic [2:0] {IDLE, TRST_LO, NAV_PRE, SHIFT, NAV_POST, RESP} state_t;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_TRST  = 2'b01;
  localparam logic [1:0] OP_IR    = 2'b10;
  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  step_q, step_d;
  logic [7:0]  div_q, div_d;
  logic        arm_q, arm_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic        trst_q, trst_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  state_t      nstate;
  logic [4:0]  nstep;
  logic [4:0]  last_step;
  logic        launch;
  logic        phase_end;

  // Index of the final period of the current state's sequence.
  always_comb begin
    last_step = 5'd0;
    case (state_q)
      NAV_PRE:  last_step = (op_q == OP_RESET) ? 5'd5 : (op_q == OP_IR) ? 5'd3 : 5'd2;
      TRST_LO:  last_step = 5'd2;
      SHIFT:    last_step = len_q;
      NAV_POST: last_step = 5'd1;
      default:  last_step = 5'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    step_d      = step_q;
    div_d       = div_q;
    arm_d       = arm_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_d      = trst_q;
    rsp_data_d  = rsp_data_q;
    nstate      = state_q;
    nstep       = step_q;
    launch      = 1'b0;
    phase_end   = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d       = cmd_op;
          len_d      = cmd_len_m1;
          data_d     = cmd_data;
          state_d    = (cmd_op == OP_TRST) ? TRST_LO : NAV_PRE;
          step_d     = 5'd0;
          div_d      = 8'd0;
          arm_d      = 1'b1;
          rsp_data_d = 32'd0;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        if (arm_q) begin
          // One setup clk after acceptance, then period 0 is launched.
          arm_d  = 1'b0;
          div_d  = 8'd0;
          nstate = state_q;
          nstep  = 5'd0;
          launch = 1'b1;
        end else begin
          div_d = phase_end ? 8'd0 : div_q + 8'd1;
          if (phase_end && !tck_q) begin
            tck_d = 1'b1;
            if (state_q == SHIFT) rsp_data_d[step_q] = tdo;
          end else if (phase_end && tck_q) begin
            tck_d = 1'b0;
            if (step_q != last_step) begin
              nstep = step_q + 5'd1;
            end else begin
              nstep = 5'd0;
              case (state_q)
                NAV_PRE: nstate = (op_q == OP_RESET) ? RESP : SHIFT;
                SHIFT:   nstate = NAV_POST;
                default: nstate = RESP;
              endcase
            end
            state_d = nstate;
            step_d  = nstep;
            launch  = (nstate != RESP);
          end
        end
      end
    endcase

    // Pin values for the period being opened (falling-edge launch).
    if (launch) begin
      tms_d  = 1'b0;
      tdi_d  = 1'b0;
      trst_d = 1'b1;
      case (nstate)
        NAV_PRE: begin
          if (op_q == OP_RESET)   tms_d = (nstep != 5'd5);
          else if (op_q == OP_IR) tms_d = (nstep < 5'd2);
          else                    tms_d = (nstep == 5'd0);
        end
        TRST_LO: begin
          tms_d  = (nstep < 5'd2);
          trst_d = (nstep >= 5'd2);
        end
        SHIFT: begin
          tms_d = (nstep == len_q);
          tdi_d = data_q[nstep];
        end
        NAV_POST: tms_d = (nstep == 5'd0);
        default: ;
      endcase
    end

    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 2'd0;
      len_q       <= 5'd0;
      data_q      <= 32'd0;
      step_q      <= 5'd0;
      div_q       <= 8'd0;
      arm_q       <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b1;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      step_q      <= step_d;
      div_q       <= div_d;
      arm_q       <= arm_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_q      <= trst_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign trst      = trst_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Self-checking bench for jtag_host_driver. The expected pin sequence of each
// command is derived from the command rules (TMS tables, data bits, period
// arithmetic) and compared on every clk. Literal values pin the model.
module tb_jtag_host_driver;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len_m1;
  logic [31:0] cmd_data, rsp_data;
  logic        tck, tms, tdi, trst, tdo;

  int n_err = 0;
  int n_checks = 0;

  // Test-logic model: either a 1-bit loopback flop clocked on tck rise, or a
  // TDO pattern indexed by the number of tck rises since command acceptance.
  logic        loop_mode = 1'b0;
  logic        loop_ff = 1'b0;
  logic [63:0] pat = 64'd0;
  int          rise_cnt = 0;
  int          base = 0;
  int          tdo_idx;

  jtag_host_driver #(.TCK_DIV(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len_m1(cmd_len_m1), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
  );

  always #5 clk = ~clk;

  always @(posedge tck) begin
    loop_ff  <= tdi;
    rise_cnt <= rise_cnt + 1;
  end

  always_comb begin
    tdo_idx = rise_cnt - base;
    if (loop_mode)                     tdo = loop_ff;
    else if (tdo_idx >= 0 && tdo_idx < 64) tdo = pat[tdo_idx];
    else                               tdo = 1'b0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk1("ready_before_cmd", cmd_ready, 1'b1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] lm1, input logic [31:0] data,
                         input bit lp, input logic [63:0] p, input int hold, input bit keep_valid,
                         input int lit_edge, input logic [31:0] lit_rsp);
    bit          etms[$];
    bit          etdi[$];
    bit          etrst[$];
    int          n, pre, np, k, ph, lo_cnt, rise_edge;
    logic [31:0] ersp;
    n = int'(lm1) + 1;
    ersp = 32'd0;
    pre = 0;
    case (op)
      2'b00: for (int i = 0; i < 6; i++) begin etms.push_back(i != 5); etdi.push_back(0); etrst.push_back(1); end
      2'b01: for (int i = 0; i < 3; i++) begin etms.push_back(i < 2); etdi.push_back(0); etrst.push_back(i >= 2); end
      default: begin
        if (op == 2'b10) begin
          pre = 4;
          for (int i = 0; i < 4; i++) begin etms.push_back(i < 2); etdi.push_back(0); etrst.push_back(1); end
        end else begin
          pre = 3;
          for (int i = 0; i < 3; i++) begin etms.push_back(i == 0); etdi.push_back(0); etrst.push_back(1); end
        end
        for (int i = 0; i < n; i++) begin
          etms.push_back(i == n - 1);
          etdi.push_back(data[i]);
          etrst.push_back(1);
          if (lp) ersp[i] = (i == 0) ? 1'b0 : data[i-1];
          else    ersp[i] = p[pre+i];
        end
        for (int i = 0; i < 2; i++) begin etms.push_back(i == 0); etdi.push_back(0); etrst.push_back(1); end
      end
    endcase
    np = etms.size();

    wait_ready();
    cmd_op = op; cmd_len_m1 = lm1; cmd_data = data; cmd_valid = 1'b1;
    loop_mode = lp; pat = p;
    @(posedge clk);
    base = rise_cnt;
    @(negedge clk);
    if (!keep_valid) cmd_valid = 1'b0;
    cmd_op = ~op; cmd_len_m1 = ~lm1; cmd_data = ~data;
    chk1("ready_low_after_accept", cmd_ready, 1'b0);

    rise_edge = -1;
    lo_cnt = 0;
    for (int c = 1; c <= 2*D*np + 1; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rise_edge < 0) rise_edge = c;
      if (c <= 2*D*np) begin
        k  = (c - 1) / (2*D);
        ph = (c - 1) % (2*D);
        chk1("tck", tck, ph >= D);
        chk1("tms", tms, etms[k]);
        chk1("tdi", tdi, etdi[k]);
        chk1("trst", trst, etrst[k]);
        chk1("rsp_valid_early", rsp_valid, 1'b0);
        chk1("ready_busy", cmd_ready, 1'b0);
        if (trst === 1'b0) lo_cnt++;
      end else begin
        chk1("tck_idle", tck, 1'b0);
        chk1("rsp_valid_rise", rsp_valid, 1'b1);
        chk32("rsp_data_model", rsp_data, ersp);
        chk32("rsp_data_literal", rsp_data, lit_rsp);
        chk1("ready_in_resp", cmd_ready, 1'b0);
      end
    end
    chk32("rsp_valid_edge", 32'(rise_edge), 32'(lit_edge));
    if (op == 2'b01) chk32("trst_low_clks", 32'(lo_cnt), 32'(4*D));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk1("rsp_valid_hold", rsp_valid, 1'b1);
      chk32("rsp_data_hold", rsp_data, lit_rsp);
      chk1("ready_hold", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk1("rsp_valid_after_hs", rsp_valid, 1'b0);
    chk1("ready_after_hs", cmd_ready, 1'b1);
    rsp_ready = 1'b0;
    $display("cmd op=%b len_m1=%0d data=%h periods=%0d rsp_edge=%0d rsp=%h", op, lm1, data, np, rise_edge, ersp);
  endtask

  initial begin
    int stray;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len_m1 = 5'd0; cmd_data = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_tck", tck, 1'b0);
    chk1("rst_tms", tms, 1'b1);
    chk1("rst_tdi", tdi, 1'b0);
    chk1("rst_trst", trst, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_data", rsp_data, 32'd0);
    chk1("rst_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    #1 chk1("ready_at_release", cmd_ready, 1'b0);
    @(negedge clk);
    chk1("ready_after_release", cmd_ready, 1'b1);
    $display("reset released, cmd_ready=%b", cmd_ready);

    run_cmd(2'b00, 5'd0,  32'hDEAD_BEEF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  0, 25,  32'h0000_0000);
    run_cmd(2'b10, 5'd3,  32'h0000_0005, 0, 64'hFFFF_FFFF_FFFF_FFB0, 10, 0, 41,  32'h0000_000B);
    run_cmd(2'b11, 5'd31, 32'hA5A5_1234, 1, 64'h0,                   2,  0, 149, 32'h4B4A_2468);
    run_cmd(2'b01, 5'd5,  32'h0000_1234, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1,  1, 13,  32'h0000_0000);
    run_cmd(2'b11, 5'd0,  32'h0000_0001, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0,  0, 25,  32'h0000_0001);

    // Abort in the 5th SHIFT period of a SHIFT_DR (overall period 7).
    wait_ready();
    cmd_op = 2'b11; cmd_len_m1 = 5'd7; cmd_data = 32'h0000_00FF; cmd_valid = 1'b1;
    loop_mode = 1'b0; pat = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    base = rise_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 31; c++) @(negedge clk);
    chk1("abort_tck_high", tck, 1'b1);
    chk1("abort_tdi_data", tdi, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("abort_tck", tck, 1'b0);
    chk1("abort_tms", tms, 1'b1);
    chk1("abort_tdi", tdi, 1'b0);
    chk1("abort_trst", trst, 1'b1);
    chk1("abort_rsp_valid", rsp_valid, 1'b0);
    chk32("abort_rsp_data", rsp_data, 32'd0);
    chk1("abort_ready", cmd_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("abort_ready_release", cmd_ready, 1'b1);
    stray = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || tck !== 1'b0) stray++;
    end
    chk32("abort_no_rsp", 32'(stray), 32'd0);
    $display("abort test: stray activity cycles=%0d", stray);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
